// File: rtl/posit_serial_loader.sv
// Assembles framed, MSB-first serial bits into N-bit posit words and buffers them in a FIFO.
// The head word is presented with valid/ready and carries zero/NaR flags for the converter.
module posit_serial_loader #(
    parameter int unsigned N     = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sin_valid,
    input  logic         sin_frame,
    input  logic         sin_bit,
    output logic [N-1:0] out_word,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_zero,
    output logic         out_nar,
    output logic         frame_err,
    output logic         ovf_err,
    output logic [7:0]   drop_cnt
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(N);
    localparam logic [N-1:0] NAR_WORD = {1'b1, {(N-1){1'b0}}};

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   sr_q, sr_d;
    logic [N-1:0]   sr_shift;
    logic           word_done;
    logic           frame_err_d;

    logic [N-1:0]   mem [DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic           empty, full, pop, push, drop;

    assign sr_shift = {sr_q[N-2:0], sin_bit};

    // Deserializer next-state: framing, bit counting and word completion
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        word_done   = 1'b0;
        frame_err_d = 1'b0;
        if (sin_valid) begin
            case (state_q)
                IDLE: begin
                    if (sin_frame) begin
                        sr_d    = sr_shift;
                        cnt_d   = CW'(1);
                        state_d = SHIFT;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                SHIFT: begin
                    if (sin_frame) begin
                        sr_d        = sr_shift;
                        cnt_d       = CW'(1);
                        frame_err_d = 1'b1;
                    end else if (cnt_q == CW'(N - 1)) begin
                        sr_d      = sr_shift;
                        cnt_d     = '0;
                        word_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        sr_d  = sr_shift;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Pointers carry a wrap bit; full when only the wrap bits differ
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = out_valid & out_ready;
    assign push  = word_done & (~full | pop);
    assign drop  = word_done & full & ~pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            frame_err <= 1'b0;
            ovf_err   <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            frame_err <= frame_err_d;
            ovf_err   <= drop;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Storage needs no reset: contents are only visible behind the pointers
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= sr_shift;
    end

    assign out_valid = ~empty;
    assign out_word  = out_valid ? mem[rd_ptr_q[AW-1:0]] : '0;
    assign out_zero  = out_valid & (out_word == '0);
    assign out_nar   = out_valid & (out_word == NAR_WORD);

endmodule

// File: tb/tb_posit_serial_loader.sv
// Bench for posit_serial_loader: directed serial frames checked against a queue-based model
// every cycle, plus literal expectations on the key cycles.
`timescale 1ns/1ps
module tb_posit_serial_loader;
    localparam int unsigned N     = 16;
    localparam int unsigned DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         sin_valid, sin_frame, sin_bit;
    logic         out_ready;
    logic [N-1:0] out_word;
    logic         out_valid, out_zero, out_nar, frame_err, ovf_err;
    logic [7:0]   drop_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    posit_serial_loader #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin_valid (sin_valid),
        .sin_frame (sin_frame),
        .sin_bit   (sin_bit),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_zero  (out_zero),
        .out_nar   (out_nar),
        .frame_err (frame_err),
        .ovf_err   (ovf_err),
        .drop_cnt  (drop_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame collector plus a bounded queue of whole words
    int m_q[$];
    bit m_in_frame = 1'b0;
    int m_nbits    = 0;
    int m_acc      = 0;
    int m_drops    = 0;
    bit m_ferr     = 1'b0;
    bit m_ovf      = 1'b0;
    bit model_live = 1'b0;

    always @(posedge clk) begin
        bit pop;
        bit done;
        pop    = 1'b0;
        done   = 1'b0;
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
        if (rst) begin
            m_q.delete();
            m_in_frame = 1'b0;
            m_nbits    = 0;
            m_acc      = 0;
            m_drops    = 0;
            model_live = 1'b1;
        end else begin
            pop = (m_q.size() > 0) && (out_ready === 1'b1);
            if (sin_valid === 1'b1) begin
                if (sin_frame === 1'b1) begin
                    if (m_in_frame) m_ferr = 1'b1;
                    m_in_frame = 1'b1;
                    m_acc      = int'(sin_bit);
                    m_nbits    = 1;
                end else if (!m_in_frame) begin
                    m_ferr = 1'b1;
                end else begin
                    m_acc   = (m_acc * 2 + int'(sin_bit)) % (1 << N);
                    m_nbits = m_nbits + 1;
                    if (m_nbits == int'(N)) begin
                        done       = 1'b1;
                        m_in_frame = 1'b0;
                        m_nbits    = 0;
                    end
                end
            end
            if (pop) void'(m_q.pop_front());
            if (done) begin
                if (m_q.size() < int'(DEPTH)) m_q.push_back(m_acc);
                else begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops = m_drops + 1;
                end
            end
        end
    end

    logic [N-1:0] got[$];
    logic [N-1:0] exp_q[$];
    int           ferr_seen = 0;

    // Per-cycle comparison against the model, sampled mid-cycle
    always @(negedge clk) begin
        int  exp_word;
        bit  exp_valid;
        if (model_live) begin
            exp_valid = (m_q.size() > 0);
            exp_word  = exp_valid ? m_q[0] : 0;
            chk("cyc_valid", 32'(out_valid), 32'(exp_valid));
            chk("cyc_word", 32'(out_word), 32'(exp_word));
            chk("cyc_zero", 32'(out_zero), 32'(exp_valid && exp_word == 0));
            chk("cyc_nar", 32'(out_nar), 32'(exp_valid && exp_word == 32'h8000));
            chk("cyc_frame_err", 32'(frame_err), 32'(m_ferr));
            chk("cyc_ovf_err", 32'(ovf_err), 32'(m_ovf));
            chk("cyc_drop_cnt", 32'(drop_cnt), 32'(m_drops));
            if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back(out_word);
            if (frame_err === 1'b1) ferr_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic f, input logic b);
        sin_valid = 1'b1;
        sin_frame = f;
        sin_bit   = b;
        tick();
    endtask

    task automatic send_word(input logic [N-1:0] w);
        for (int i = int'(N) - 1; i >= 0; i--) send_bit(logic'(i == int'(N) - 1), w[i]);
    endtask

    task automatic idle(input int n);
        sin_valid = 1'b0;
        sin_frame = 1'b0;
        sin_bit   = 1'b0;
        repeat (n) tick();
    endtask

    task automatic check_got(input string name);
        chk({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got.size()) chk(name, 32'(got[i]), 32'(exp_q[i]));
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] w;
        rst = 1'b1; sin_valid = 1'b0; sin_frame = 1'b0; sin_bit = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_word", 32'(out_word), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_ovf_err", 32'(ovf_err), 32'h0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        rst = 1'b0;

        // Single word, one-cycle latency, immediate pop
        out_ready = 1'b1; got.delete();
        send_word(16'h4000);
        sin_valid = 1'b0;
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_word", 32'(out_word), 32'h4000);
        chk("t1_zero", 32'(out_zero), 32'h0);
        chk("t1_nar", 32'(out_nar), 32'h0);
        tick();
        chk("t1_empty", 32'(out_valid), 32'h0);
        idle(2);
        exp_q = '{16'h4000};
        check_got("t1_order");

        // Zero then NaR, back-to-back
        got.delete();
        send_word(16'h0000);
        chk("t2_zero", 32'(out_zero), 32'h1);
        send_word(16'h8000);
        chk("t2_nar", 32'(out_nar), 32'h1);
        chk("t2_nar_not_zero", 32'(out_zero), 32'h0);
        idle(3);
        exp_q = '{16'h0000, 16'h8000};
        check_got("t2_order");

        // Overflow on the fifth word with no consumer
        out_ready = 1'b0; got.delete();
        for (int k = 1; k <= 5; k++) send_word(16'(k * 16'h1111));
        chk("t3_ovf", 32'(ovf_err), 32'h1);
        chk("t3_drop", 32'(drop_cnt), 32'h1);
        idle(1);
        chk("t3_ovf_pulse", 32'(ovf_err), 32'h0);
        out_ready = 1'b1;
        idle(6);
        exp_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        check_got("t3_order");

        // Full FIFO with a pop in the completion cycle accepts the word
        out_ready = 1'b0; got.delete();
        for (int k = 1; k <= 4; k++) send_word(16'(k * 16'h1111));
        idle(1);
        w = 16'h6666;
        for (int i = int'(N) - 1; i >= 1; i--) send_bit(logic'(i == int'(N) - 1), w[i]);
        out_ready = 1'b1;
        send_bit(1'b0, w[0]);
        chk("t4_no_ovf", 32'(ovf_err), 32'h0);
        chk("t4_drop", 32'(drop_cnt), 32'h1);
        idle(6);
        exp_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h6666};
        check_got("t4_order");

        // Restart mid-frame, then a stray bit in idle
        got.delete(); ferr_seen = 0;
        w = 16'hABCD;
        for (int i = int'(N) - 1; i >= int'(N) - 7; i--) send_bit(logic'(i == int'(N) - 1), w[i]);
        send_word(16'h1234);
        idle(2);
        chk("t5_ferr_pulses", 32'(ferr_seen), 32'h1);
        exp_q = '{16'h1234};
        check_got("t5_order");
        got.delete();
        send_bit(1'b0, 1'b1);
        sin_valid = 1'b0;
        chk("t5_stray", 32'(frame_err), 32'h1);
        idle(3);
        exp_q.delete();
        check_got("t5_stray_out");

        // Reset mid-frame discards the partial word
        got.delete();
        w = 16'h5A5A;
        for (int i = int'(N) - 1; i >= int'(N) - 9; i--) send_bit(logic'(i == int'(N) - 1), w[i]);
        sin_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_drop_after_rst", 32'(drop_cnt), 32'h0);
        send_word(16'h00FF);
        idle(3);
        exp_q = '{16'h00FF};
        check_got("t6_order");

        // Saturating drop counter
        out_ready = 1'b0; got.delete();
        for (int k = 0; k < 260; k++) send_word(16'(k));
        chk("sat_drop", 32'(drop_cnt), 32'hFF);
        idle(1);
        out_ready = 1'b1;
        idle(6);
        exp_q = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
        check_got("sat_order");

        // Reset with three entries queued empties the FIFO and clears the counter
        out_ready = 1'b0; got.delete();
        send_word(16'hA001); send_word(16'hA002); send_word(16'hA003);
        idle(1);
        chk("t6_three_valid", 32'(out_valid), 32'h1);
        chk("t6_three_head", 32'(out_word), 32'hA001);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_rst_valid", 32'(out_valid), 32'h0);
        chk("t6_rst_word", 32'(out_word), 32'h0);
        chk("t6_rst_drop", 32'(drop_cnt), 32'h0);
        out_ready = 1'b1;
        idle(3);
        exp_q.delete();
        check_got("t6_rst_out");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
